// File: rtl/fxp_mul_seq.sv
// fxp_mul_seq: sequential signed fixed-point shift-add multiplier with saturation; FXP_MUL_ROUND_EN enables round-half-away-from-zero
module fxp_mul_seq #(
  parameter int N = 16,
  parameter int FRAC = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [N-1:0] A,
  input  logic [N-1:0] B,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [N-1:0] Result,
  output logic         sat
);
  typedef enum logic [1:0] {IDLE, CALC, NORM, DONE} state_t;
  localparam int CW = $clog2(N);
  localparam logic [2*N-1:0] MAXP = {{(N+1){1'b0}}, {(N-1){1'b1}}};
  localparam logic [2*N-1:0] MAXN = {{N{1'b0}}, 1'b1, {(N-1){1'b0}}};
  state_t state, state_n;
  logic in_ready_n, out_valid_n, sat_n, neg, neg_n, ovf;
  logic [N-1:0] result_n, mb, mb_n, a_mag, b_mag, lim, res_norm;
  logic [2*N-1:0] ma, ma_n, acc, acc_n, m;
  logic [CW-1:0] cnt, cnt_n;
  assign a_mag = A[N-1] ? -A : A;
  assign b_mag = B[N-1] ? -B : B;
`ifdef FXP_MUL_ROUND_EN
  localparam logic [2*N-1:0] HALF = ({{(2*N-1){1'b0}}, 1'b1} << FRAC) >> 1;
  assign m = (acc + HALF) >> FRAC;
`else
  assign m = acc >> FRAC;
`endif
  assign ovf = neg ? (m > MAXN) : (m > MAXP);
  assign lim = neg ? MAXN[N-1:0] : MAXP[N-1:0];
  assign res_norm = ovf ? lim : (neg ? -m[N-1:0] : m[N-1:0]);
  // next-state and datapath updates; each state holds everything it does not touch
  always_comb begin
    state_n = state;
    in_ready_n = in_ready;
    out_valid_n = out_valid;
    result_n = Result;
    sat_n = sat;
    neg_n = neg;
    ma_n = ma;
    mb_n = mb;
    acc_n = acc;
    cnt_n = cnt;
    case (state)
      IDLE:
        if (in_valid && in_ready) begin
          state_n = CALC;
          in_ready_n = 1'b0;
          ma_n = {{N{1'b0}}, a_mag};
          mb_n = b_mag;
          acc_n = '0;
          cnt_n = '0;
          neg_n = A[N-1] ^ B[N-1];
        end else begin
          in_ready_n = 1'b1;
        end
      CALC: begin
        acc_n = acc + (mb[0] ? ma : '0);
        ma_n = ma << 1;
        mb_n = mb >> 1;
        cnt_n = cnt + CW'(1);
        state_n = (cnt == CW'(N-1)) ? NORM : CALC;
      end
      NORM: begin
        state_n = DONE;
        out_valid_n = 1'b1;
        result_n = res_norm;
        sat_n = ovf;
      end
      DONE:
        if (out_ready) begin
          state_n = IDLE;
          out_valid_n = 1'b0;
          in_ready_n = 1'b1;
        end
      default: state_n = IDLE;
    endcase
  end
  // state and datapath registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      in_ready <= 1'b0;
      out_valid <= 1'b0;
      Result <= '0;
      sat <= 1'b0;
      neg <= 1'b0;
      ma <= '0;
      mb <= '0;
      acc <= '0;
      cnt <= '0;
    end else begin
      state <= state_n;
      in_ready <= in_ready_n;
      out_valid <= out_valid_n;
      Result <= result_n;
      sat <= sat_n;
      neg <= neg_n;
      ma <= ma_n;
      mb <= mb_n;
      acc <= acc_n;
      cnt <= cnt_n;
    end
  end
endmodule

// File: tb/tb_fxp_mul_seq.sv
// tb_fxp_mul_seq: directed table-driven bench for fxp_mul_seq at N=16, FRAC=8
module tb_fxp_mul_seq;
  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b1;
  logic in_ready, out_valid, sat;
  logic [15:0] A = '0, B = '0, Result;
  int n_chk = 0, n_fail = 0;
  typedef struct {logic [15:0] a; logic [15:0] b; logic [15:0] res; logic s;} vec_t;
  vec_t vecs[14];
  fxp_mul_seq #(.N(16), .FRAC(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .A(A), .B(B),
    .out_valid(out_valid), .out_ready(out_ready), .Result(Result), .sat(sat)
  );
  always #5 clk = ~clk;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask
  task automatic start(input logic [15:0] a, input logic [15:0] b);
    @(negedge clk);
    for (int i = 0; i < 50 && !in_ready; i++) @(negedge clk);
    chk("in_ready_before_accept", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    A = a;
    B = b;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    A = 16'h5A5A;
    B = 16'hA5A5;
    chk("in_ready_after_accept", 32'(in_ready), 32'd0);
  endtask
  task automatic wait_valid(output int lat);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!out_valid && lat < 100);
    if (!out_valid) chk("out_valid_timeout", 32'(out_valid), 32'd1);
  endtask
  task automatic run(input string name, input vec_t v);
    int lat;
    start(v.a, v.b);
    wait_valid(lat);
    chk({name, "_latency"}, 32'(lat), 32'd17);
    chk({name, "_result"}, 32'(Result), 32'(v.res));
    chk({name, "_sat"}, 32'(sat), 32'(v.s));
    @(posedge clk);
    #1;
    chk({name, "_out_valid_drop"}, 32'(out_valid), 32'd0);
    chk({name, "_in_ready_back"}, 32'(in_ready), 32'd1);
  endtask
  initial begin
    int lat;
    logic [15:0] hr;
    logic hs;
    vecs[0] = '{16'h0180, 16'h0200, 16'h0300, 1'b0};
    vecs[1] = '{16'hFE80, 16'h0200, 16'hFD00, 1'b0};
    vecs[2] = '{16'h0000, 16'h8000, 16'h0000, 1'b0};
    vecs[3] = '{16'h7FFF, 16'h7FFF, 16'h7FFF, 1'b1};
    vecs[4] = '{16'h8000, 16'h7FFF, 16'h8000, 1'b1};
    vecs[5] = '{16'h8000, 16'h0100, 16'h8000, 1'b0};
`ifdef FXP_MUL_ROUND_EN
    vecs[6] = '{16'h0001, 16'h0080, 16'h0001, 1'b0};
    vecs[7] = '{16'hFFFF, 16'h0080, 16'hFFFF, 1'b0};
    vecs[8] = '{16'h0003, 16'h0055, 16'h0001, 1'b0};
`else
    vecs[6] = '{16'h0001, 16'h0080, 16'h0000, 1'b0};
    vecs[7] = '{16'hFFFF, 16'h0080, 16'h0000, 1'b0};
    vecs[8] = '{16'h0003, 16'h0055, 16'h0000, 1'b0};
`endif
    vecs[9] = '{16'hFF00, 16'hFF00, 16'h0100, 1'b0};
    vecs[10] = '{16'h4000, 16'h0200, 16'h7FFF, 1'b1};
    vecs[11] = '{16'hC000, 16'h0200, 16'h8000, 1'b0};
    vecs[12] = '{16'h0280, 16'hFD00, 16'hF880, 1'b0};
    vecs[13] = '{16'h7FFF, 16'h0100, 16'h7FFF, 1'b0};
    #1;
    chk("reset_in_ready", 32'(in_ready), 32'd0);
    chk("reset_out_valid", 32'(out_valid), 32'd0);
    chk("reset_result", 32'(Result), 32'd0);
    chk("reset_sat", 32'(sat), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("release_in_ready", 32'(in_ready), 32'd1);
    foreach (vecs[i]) run($sformatf("vec%0d", i), vecs[i]);
    out_ready = 1'b0;
    start(16'h0180, 16'hFE00);
    wait_valid(lat);
    hr = Result;
    hs = sat;
    chk("stall_result", 32'(hr), 32'h0000FD00);
    chk("stall_sat", 32'(hs), 32'd0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      in_valid = ~in_valid;
      A = A + 16'h0111;
      B = B ^ 16'h0F0F;
      @(posedge clk);
      #1;
      chk("stall_out_valid", 32'(out_valid), 32'd1);
      chk("stall_hold_result", 32'(Result), 32'(hr));
      chk("stall_hold_sat", 32'(sat), 32'(hs));
      chk("stall_in_ready", 32'(in_ready), 32'd0);
    end
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("stall_release_out_valid", 32'(out_valid), 32'd0);
    chk("stall_release_in_ready", 32'(in_ready), 32'd1);
    start(16'h0180, 16'h0200);
    repeat (4) @(posedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_out_valid", 32'(out_valid), 32'd0);
    chk("abort_result", 32'(Result), 32'd0);
    chk("abort_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    chk("abort_release_in_ready", 32'(in_ready), 32'd1);
    hs = 1'b0;
    repeat (20) begin
      @(posedge clk);
      #1;
      hs = hs | out_valid;
    end
    chk("abort_no_result", 32'(hs), 32'd0);
    run("after_abort", vecs[0]);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
